// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the display readback path.
// Segment codes are active-low, bit order [6]=g .. [0]=a.
package seg7_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Frame tracker: DONE lasts exactly one cycle and is the frame_done pulse.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } frame_state_e;

    // Width of a digit index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decoder: active-low 7-segment pattern to BCD value,
// with separate flags for the blank pattern and for unknown patterns.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0]       seg,
    output logic [BCD_W-1:0] bcd,
    output logic             is_blank,
    output logic             is_illegal
);

    // Exact match against the ten digit glyphs and blank; anything else is illegal.
    always_comb begin
        bcd        = '0;
        is_blank   = 1'b0;
        is_illegal = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_to_bcd_reader.sv
// Readback monitor for a multiplexed 7-segment display bus. A sample is
// committed once the whole bus (selects + segments) has been stable long
// enough; committed digits are collected into frames and snapshotted when
// every position has been seen. Handshake-free: outputs are plain registers
// plus single-cycle pulses (frame_done, err) that carry no backpressure.
module display_to_bcd_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    seg_in,
    input  logic [N_DIGITS-1:0]           sel_in,
    output logic [4*N_DIGITS-1:0]         digits_out,
    output logic [N_DIGITS-1:0]           digit_valid,
    output logic [4*N_DIGITS-1:0]         frame_bcd,
    output logic                          frame_done,
    output logic                          err,
    output logic [idx_w(N_DIGITS)-1:0]    err_idx
);

    localparam int              IDX_W      = idx_w(N_DIGITS);
    localparam int              S_W        = N_DIGITS + 7;
    localparam logic [7:0]      CNT_MAX    = 8'(STABLE_CYCLES);
    localparam logic [7:0]      CNT_COMMIT = 8'(STABLE_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] ALL_SEEN = '1;

    // Sample register and stability counter
    logic [S_W-1:0]            s_q, s_d;
    logic [7:0]                cnt_q, cnt_d;
    // Per-digit state
    logic [4*N_DIGITS-1:0]     digits_q, digits_d;
    logic [N_DIGITS-1:0]       valid_q, valid_d;
    logic [N_DIGITS-1:0]       seen_q, seen_d;
    logic [N_DIGITS-1:0]       seen_nx;
    // Frame and error reporting
    logic [4*N_DIGITS-1:0]     frame_q, frame_d;
    logic                      err_q, err_d;
    logic [IDX_W-1:0]          err_idx_q, err_idx_d;
    frame_state_e              state_q, state_d;

    logic [S_W-1:0]            in_w;
    logic                      same_w;
    logic                      commit_w;
    logic [3:0]                low_cnt;
    logic [IDX_W-1:0]          low_idx;
    logic                      sel_one;
    logic                      sel_multi;
    logic [BCD_W-1:0]          dec_bcd;
    logic                      dec_blank;
    logic                      dec_illegal;
    logic                      frame_fire;

    assign in_w     = {sel_in, seg_in};
    assign same_w   = (in_w == s_q);
    // Commit fires once per stable run: the counter saturates past CNT_COMMIT.
    assign commit_w = same_w && (cnt_q == CNT_COMMIT);

    // Decode the held sample; on a commit edge it equals the live input.
    seg7_to_bcd u_dec (
        .seg        (s_q[6:0]),
        .bcd        (dec_bcd),
        .is_blank   (dec_blank),
        .is_illegal (dec_illegal)
    );

    // Capture the bus every edge and count how long it has stayed unchanged.
    always_comb begin
        s_d   = in_w;
        cnt_d = 8'd0;
        if (same_w) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // Count active (low) selects and remember which one was low.
    always_comb begin
        low_cnt = 4'd0;
        low_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!s_q[7+i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = IDX_W'(i);
            end
        end
    end

    assign sel_one   = (low_cnt == 4'd1);
    assign sel_multi = (low_cnt > 4'd1);

    // Apply a committed sample to the digit registers, seen mask and error pulse.
    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        seen_nx   = seen_q;
        err_d     = 1'b0;
        err_idx_d = err_idx_q;
        if (commit_w) begin
            if (sel_multi) begin
                err_d = 1'b1;
            end else if (sel_one) begin
                if (dec_illegal) begin
                    err_d     = 1'b1;
                    err_idx_d = low_idx;
                end
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (!s_q[7+i]) begin
                        if (dec_illegal) begin
                            valid_d[i] = 1'b0;
                        end else begin
                            digits_d[4*i +: 4] = dec_blank ? 4'd0 : dec_bcd;
                            valid_d[i]         = !dec_blank;
                            seen_nx[i]         = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Frame FSM: enter DONE for one cycle when the mask fills, snapshot and restart.
    always_comb begin
        frame_fire = (seen_nx == ALL_SEEN);
        state_d    = ST_COLLECT;
        seen_d     = seen_nx;
        frame_d    = frame_q;
        case (state_q)
            ST_COLLECT, ST_DONE: begin
                if (frame_fire) begin
                    state_d = ST_DONE;
                    seen_d  = '0;
                    frame_d = digits_d;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q       <= '1;
            cnt_q     <= 8'd0;
            digits_q  <= '0;
            valid_q   <= '0;
            seen_q    <= '0;
            frame_q   <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            state_q   <= ST_COLLECT;
        end else begin
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            state_q   <= state_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign frame_bcd   = frame_q;
    assign frame_done  = (state_q == ST_DONE);
    assign err         = err_q;
    assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_display_to_bcd_reader.sv
// Bench for display_to_bcd_reader: directed table, hand sequences for the
// multi-cycle corners, then random bus traffic; every cycle is also compared
// against a behavioural model of run-length based commits.
module tb_display_to_bcd_reader;

    localparam int N      = 4;
    localparam int STABLE = 4;
    localparam int IDX_W  = 2;
    localparam int W      = 4*N + N + 4*N + 1 + 1 + IDX_W;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       seg_in;
    logic [N-1:0]     sel_in;
    logic [4*N-1:0]   digits_out;
    logic [N-1:0]     digit_valid;
    logic [4*N-1:0]   frame_bcd;
    logic             frame_done;
    logic             err;
    logic [IDX_W-1:0] err_idx;

    always #5 clk = ~clk;

    display_to_bcd_reader #(.N_DIGITS(N), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .frame_bcd   (frame_bcd),
        .frame_done  (frame_done),
        .err         (err),
        .err_idx     (err_idx)
    );

    // Glyphs for 0..9, active-low, [6]=g .. [0]=a
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // ---------------- reference model ----------------
    // A bus value is committed when it has been seen on STABLE+1 consecutive edges.
    logic [N+6:0]   m_last;
    int             m_run = 1;
    logic [3:0]     m_dig  [N];
    bit             m_val  [N];
    bit             m_seen [N];
    logic [4*N-1:0] m_frame;
    bit             m_fd, m_err;
    int             m_eidx;
    logic [W-1:0]   exp_q[$];

    function automatic logic [W-1:0] model_pack();
        logic [4*N-1:0] d;
        logic [N-1:0]   v;
        for (int i = 0; i < N; i++) begin
            d[4*i +: 4] = m_dig[i];
            v[i]        = m_val[i];
        end
        return {d, v, m_frame, m_fd, m_err, IDX_W'(m_eidx)};
    endfunction

    task automatic model_commit(input logic [N+6:0] cur);
        logic [N-1:0] sel;
        logic [6:0]   sg;
        int           lows, k, val;
        bit           all;
        sel  = cur[N+6:7];
        sg   = cur[6:0];
        lows = $countones(~sel);
        k    = 0;
        if (lows > 1) begin
            m_err = 1;
        end else if (lows == 1) begin
            for (int i = 0; i < N; i++) if (!sel[i]) k = i;
            val = -1;
            for (int v = 0; v < 10; v++) if (seg_tab[v] == sg) val = v;
            if (val >= 0) begin
                m_dig[k] = val[3:0]; m_val[k] = 1; m_seen[k] = 1;
            end else if (sg == 7'h7F) begin
                m_dig[k] = 4'd0; m_val[k] = 0; m_seen[k] = 1;
            end else begin
                m_val[k] = 0; m_err = 1; m_eidx = k;
            end
            all = 1;
            for (int i = 0; i < N; i++) if (!m_seen[i]) all = 0;
            if (all) begin
                m_fd = 1;
                for (int i = 0; i < N; i++) begin
                    m_frame[4*i +: 4] = m_dig[i];
                    m_seen[i] = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        logic [N+6:0] cur;
        bit           hit;
        cur  = {sel_in, seg_in};
        hit  = 0;
        m_fd = 0;
        m_err = 0;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_dig[i] = 4'd0; m_val[i] = 0; m_seen[i] = 0;
            end
            m_frame = '0;
            m_eidx  = 0;
            m_last  = '1;
            m_run   = 1;
        end else begin
            if (cur == m_last) begin
                if (m_run <= STABLE) begin
                    m_run = m_run + 1;
                    hit   = (m_run == STABLE + 1);
                end
            end else begin
                m_last = cur;
                m_run  = 1;
            end
            if (hit) model_commit(cur);
        end
        exp_q.push_back(model_pack());
    end

    // ---------------- scoreboard / driver tasks ----------------
    int n_vec = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    task automatic tick();
        logic [W-1:0] exp, act;
        @(negedge clk);
        act = {digits_out, digit_valid, frame_bcd, frame_done, err, err_idx};
        if (frame_done) fd_cnt++;
        if (err) err_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_empty at %0t: got %h, no expected entry", $time, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_bad++;
                $display("FAIL scoreboard at %0t: got %h expected %h", $time, act, exp);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] s, input logic [6:0] g, input int cycles);
        sel_in = s;
        seg_in = g;
        repeat (cycles) tick();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  seg;
        int          hold;
        int          idx;
        logic [3:0]  exp_bcd;
        logic        exp_valid;
        logic        chk_frame;
        logic [15:0] exp_frame;
        int          exp_fd;
        int          exp_err;
        logic [1:0]  exp_eidx;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int fd0, er0;
        logic [N-1:0] rs, b1, b2;
        logic [6:0]   rg;
        int           r;

        tbl[0] = '{4'b1110, seg_tab[1], 8, 0, 4'd1, 1'b1, 1'b0, 16'h0000, 0, 0, 2'd0};
        tbl[1] = '{4'b1101, seg_tab[2], 8, 1, 4'd2, 1'b1, 1'b0, 16'h0000, 0, 0, 2'd0};
        tbl[2] = '{4'b1011, seg_tab[3], 8, 2, 4'd3, 1'b1, 1'b0, 16'h0000, 0, 0, 2'd0};
        tbl[3] = '{4'b0111, seg_tab[4], 8, 3, 4'd4, 1'b1, 1'b1, 16'h4321, 1, 0, 2'd0};
        tbl[4] = '{4'b1110, seg_tab[5], 8, 0, 4'd5, 1'b1, 1'b1, 16'h4321, 1, 0, 2'd0};
        tbl[5] = '{4'b1101, seg_tab[6], 8, 1, 4'd6, 1'b1, 1'b0, 16'h0000, 1, 0, 2'd0};
        tbl[6] = '{4'b1011, seg_tab[7], 8, 2, 4'd7, 1'b1, 1'b0, 16'h0000, 1, 0, 2'd0};
        tbl[7] = '{4'b0111, seg_tab[8], 8, 3, 4'd8, 1'b1, 1'b1, 16'h8765, 2, 0, 2'd0};
        tbl[8] = '{4'b1011, 7'b0101010, 8, 2, 4'd7, 1'b0, 1'b1, 16'h8765, 2, 1, 2'd2};
        tbl[9] = '{4'b0111, 7'h7F,      8, 3, 4'd0, 1'b0, 1'b1, 16'h8765, 2, 1, 2'd2};

        // Reset: two edges low, then idle blanking
        rst_n  = 1'b0;
        sel_in = '1;
        seg_in = 7'h7F;
        tick();
        tick();
        chk("reset_outputs", {digits_out, digit_valid, frame_bcd, frame_done, err, err_idx}, 0);
        rst_n = 1'b1;
        fd0 = fd_cnt;
        er0 = err_cnt;
        drive('1, 7'h7F, 10);
        chk("idle_no_frame", fd_cnt - fd0, 0);
        chk("idle_no_err", err_cnt - er0, 0);
        chk("idle_digits", digits_out, 0);

        // Commit latency: nothing after E0..E3, digit present after E4
        drive(4'b1110, seg_tab[2], 4);
        chk("d0_before_commit", digit_valid[0], 0);
        drive(4'b1110, seg_tab[2], 1);
        chk("d0_commit_valid", digit_valid[0], 1);
        chk("d0_commit_value", digits_out[3:0], 2);
        drive(4'b1110, seg_tab[2], 20);
        chk("d0_hold_value", digits_out[3:0], 2);

        // Glitching segments never reach the stability threshold
        for (int i = 0; i < 6; i++) begin
            drive(4'b1101, seg_tab[3], 2);
            drive(4'b1101, seg_tab[8], 2);
        end
        chk("glitch_no_commit", digit_valid[1], 0);
        drive(4'b1101, seg_tab[3], 6);
        chk("glitch_then_stable_valid", digit_valid[1], 1);
        chk("glitch_then_stable_value", digits_out[7:4], 3);

        // Scan passes, illegal pattern, blank digit
        fd0 = fd_cnt;
        er0 = err_cnt;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].sel, tbl[i].seg, tbl[i].hold);
            chk($sformatf("tbl%0d_bcd", i), digits_out[4*tbl[i].idx +: 4], tbl[i].exp_bcd);
            chk($sformatf("tbl%0d_valid", i), digit_valid[tbl[i].idx], tbl[i].exp_valid);
            chk($sformatf("tbl%0d_frames", i), fd_cnt - fd0, tbl[i].exp_fd);
            chk($sformatf("tbl%0d_errs", i), err_cnt - er0, tbl[i].exp_err);
            chk($sformatf("tbl%0d_err_idx", i), err_idx, tbl[i].exp_eidx);
            if (tbl[i].chk_frame)
                chk($sformatf("tbl%0d_frame_bcd", i), frame_bcd, tbl[i].exp_frame);
        end

        // Multi-hot select: error, index and digits untouched
        er0 = err_cnt;
        drive(4'b1100, seg_tab[5], 8);
        chk("multihot_err", err_cnt - er0, 1);
        chk("multihot_err_idx", err_idx, 2);
        chk("multihot_digits", digits_out, 16'h0765);
        chk("multihot_valid", digit_valid, 4'b0011);

        // Blank digit 3 already counted: three more digits complete a frame
        fd0 = fd_cnt;
        drive(4'b1110, seg_tab[9], 8);
        drive(4'b1101, seg_tab[0], 8);
        drive(4'b1011, seg_tab[5], 8);
        chk("blank_frame_count", fd_cnt - fd0, 1);
        chk("blank_frame_bcd", frame_bcd, 16'h0509);

        // Reset mid-scan discards the partial frame and the snapshot
        fd0 = fd_cnt;
        drive(4'b1110, seg_tab[1], 8);
        drive(4'b1101, seg_tab[2], 8);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("midreset_frame_bcd", frame_bcd, 0);
        chk("midreset_digits", digits_out, 0);
        drive(4'b1011, seg_tab[3], 8);
        drive(4'b0111, seg_tab[4], 8);
        chk("midreset_no_frame", fd_cnt - fd0, 0);
        chk("midreset_digits_after", digits_out, 16'h4300);
        chk("midreset_valid_after", digit_valid, 4'b1100);

        // Random bus traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            b1 = 4'b0001 << $urandom_range(0, 3);
            b2 = 4'b0001 << $urandom_range(0, 3);
            if (r == 0)      rs = '1;
            else if (r == 1) rs = ~(b1 | b2);
            else             rs = ~b1;
            r = $urandom_range(0, 11);
            if (r < 10)       rg = seg_tab[r];
            else if (r == 10) rg = 7'h7F;
            else              rg = 7'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            drive(rs, rg, $urandom_range(1, 8));
        end
        drive('1, 7'h7F, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
